secure_serdes_session_ctrl: RTL and testbench

SECURE_SERDES_SESSION_CTRL -- requirements
Module: secure_serdes_session_ctrl

---
 rtl/secure_serdes_pkg.sv | 16 +
 rtl/serdes_bit_shifter.sv | 36 +++
 rtl/secure_serdes_session_ctrl.sv | 164 ++++++++++++++++
 tb/tb_secure_serdes_session_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_serdes_pkg.sv
// Shared types and defaults for the secure SERDES session controller.
package secure_serdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT
  } state_e;

  localparam int DEF_BITS    = 8;
  localparam int DEF_TIMEOUT = 15;
  // TIMEOUT overrides must stay below 2**TIMER_W.
  localparam int TIMER_W     = 8;

endpackage

// File: rtl/serdes_bit_shifter.sv
// Operand register pair: parallel load on accept, shift right by one per finished bit.
module serdes_bit_shifter
  import secure_serdes_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  output logic            a_lsb_o,
  output logic            b_lsb_o
);

  logic [BITS-1:0] a_q;
  logic [BITS-1:0] b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load_i) begin
      a_q <= a_i;
      b_q <= b_i;
    end else if (shift_i) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
    end
  end

  assign a_lsb_o = a_q[0];
  assign b_lsb_o = b_q[0];

endmodule

// File: rtl/secure_serdes_session_ctrl.sv
// Serializes operand pairs bit by bit through an external encryptor core and reassembles the cipher word.
// Optional out_parity output when SERDES_PARITY_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for operands; key writes accepted here only
// ST_ISSUE | one-cycle core_start for the current bit
// ST_WAIT  | hold operand bits, wait for core_done or timeout
// ST_EMIT  | cipher word presented until consumer handshake
module secure_serdes_session_ctrl
  import secure_serdes_pkg::*;
#(
  parameter int BITS    = DEF_BITS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  input  logic            key_wr,
  input  logic [BITS-1:0] key_in,
  output logic [BITS-1:0] key_out,
  output logic            core_start,
  output logic            core_a_bit,
  output logic            core_b_bit,
  input  logic            core_cipher,
  input  logic            core_done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            busy,
  output logic            err_timeout
`ifdef SERDES_PARITY_EN
  ,
  output logic            out_parity
`endif
);

  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;

  state_e               state_q;
  logic [BITS-1:0]      key_q;
  logic [BITS-1:0]      acc_q;
  logic [BITS-1:0]      out_data_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 in_ready_q;
  logic                 core_start_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 err_q;
  logic [BITS-1:0]      word_d;
  logic                 accept;
  logic                 last_bit;
`ifdef SERDES_PARITY_EN
  logic                 parity_q;
`endif

  assign accept   = (state_q == ST_IDLE) && in_valid && in_ready_q;
  assign last_bit = (cnt_q == CNT_W'(BITS - 1));

  always_comb begin
    word_d        = acc_q;
    word_d[cnt_q] = core_cipher;
  end

  serdes_bit_shifter #(.BITS(BITS)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .shift_i ((state_q == ST_WAIT) && core_done && !last_bit),
    .a_i     (in_a),
    .b_i     (in_b),
    .a_lsb_o (core_a_bit),
    .b_lsb_o (core_b_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      acc_q        <= '0;
      out_data_q   <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef SERDES_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (key_wr) key_q <= key_in;
          if (accept) begin
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            core_start_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // the start-pulse cycle counts as the first timer cycle
          timer_q <= TIMER_W'(1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            acc_q[cnt_q] <= core_cipher;
            if (last_bit) begin
              out_data_q  <= word_d;
`ifdef SERDES_PARITY_EN
              parity_q    <= ^word_d;
`endif
              out_valid_q <= 1'b1;
              state_q     <= ST_EMIT;
            end else begin
              cnt_q        <= cnt_q + 1'b1;
              core_start_q <= 1'b1;
              state_q      <= ST_ISSUE;
            end
          end else if (timer_q == TIMER_W'(TIMEOUT)) begin
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign key_out     = key_q;
  assign core_start  = core_start_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
`ifdef SERDES_PARITY_EN
  assign out_parity  = parity_q;
`endif

endmodule

// File: tb/tb_secure_serdes_session_ctrl.sv
// Directed bench for secure_serdes_session_ctrl with a 2-cycle core model (cipher = a ^ b ^ key bit).
module tb_secure_serdes_session_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic       key_wr;
  logic [7:0] key_in, key_out;
  logic       core_start, core_a_bit, core_b_bit;
  logic       core_cipher, core_done;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       busy, err_timeout;
`ifdef SERDES_PARITY_EN
  logic       out_parity;
`endif

  secure_serdes_session_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .key_wr(key_wr), .key_in(key_in), .key_out(key_out),
    .core_start(core_start), .core_a_bit(core_a_bit), .core_b_bit(core_b_bit),
    .core_cipher(core_cipher), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err_timeout(err_timeout)
`ifdef SERDES_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // core model
  int   drop_bit = -1;
  int   model_idx, p1_idx;
  logic p1, p1_a, p1_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= 1'b0; p1_idx <= 0; p1_a <= 1'b0; p1_b <= 1'b0;
      core_done <= 1'b0; core_cipher <= 1'b0; model_idx <= 0;
    end else begin
      if (in_valid && in_ready) model_idx <= 0;
      else if (core_start) model_idx <= model_idx + 1;
      p1     <= core_start;
      p1_idx <= model_idx;
      p1_a   <= core_a_bit;
      p1_b   <= core_b_bit;
      core_done   <= p1 && (p1_idx != drop_bit);
      core_cipher <= p1_a ^ p1_b ^ key_out[p1_idx[2:0]];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic write_key(input logic [7:0] k);
    key_wr = 1'b1; key_in = k;
    @(negedge clk);
    key_wr = 1'b0;
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b, output int c_a);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(in_ready), 32'd1);
    c_a = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    key_wr   = 1'b0;
  endtask

  task automatic wait_valid(output int c_v);
    int n = 0;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    c_v = cyc;
  endtask

  task automatic wait_start(input int nth, output int c_s);
    int starts = 0;
    c_s = -1;
    for (int n = 0; n < 200 && c_s < 0; n++) begin
      if (core_start === 1'b1) begin
        starts++;
        if (starts == nth) c_s = cyc;
      end
      if (c_s < 0) @(negedge clk);
    end
    chk("start_seen", 32'(c_s >= 0), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    chk("hs_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] key;
    logic [7:0] a;
    logic [7:0] b;
    bit         same_cycle;
    logic [7:0] exp;
    logic       par;
  } vec_t;
  vec_t vecs[3];

  initial begin
    int c_a, c_v, c_s, c_e, c_r, n, hits;
    vecs[0] = '{key: 8'h00, a: 8'hFF, b: 8'h00, same_cycle: 1'b0, exp: 8'hFF, par: 1'b0};
    vecs[1] = '{key: 8'hC3, a: 8'h12, b: 8'h34, same_cycle: 1'b1, exp: 8'hE5, par: 1'b1};
    vecs[2] = '{key: 8'h5A, a: 8'h3C, b: 8'h0F, same_cycle: 1'b0, exp: 8'h69, par: 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    key_wr = 1'b0; key_in = '0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_key", 32'(key_out), 32'h00);
    chk("rst_data", 32'(out_data), 32'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 3; i++) begin
      if (vecs[i].same_cycle) begin
        key_wr = 1'b1; key_in = vecs[i].key;
      end else begin
        write_key(vecs[i].key);
      end
      accept(vecs[i].a, vecs[i].b, c_a);
      wait_valid(c_v);
      chk($sformatf("vec%0d_latency", i), 32'(c_v - c_a), 32'd25);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_key", i), 32'(key_out), 32'(vecs[i].key));
`ifdef SERDES_PARITY_EN
      chk($sformatf("vec%0d_parity", i), 32'(out_parity), 32'(vecs[i].par));
`endif
      handshake();
    end

    // EMIT stall with a second offer pending
    accept(8'h3C, 8'h0F, c_a);
    wait_valid(c_v);
    in_a = 8'h00; in_b = 8'h00; in_valid = 1'b1;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_data !== 8'h69 || in_ready !== 1'b0 || out_valid !== 1'b1 || core_start !== 1'b0) hits++;
    end
    chk("stall_hold_errors", 32'(hits), 32'd0);
    chk("stall_data", 32'(out_data), 32'h69);
    in_valid = 1'b0;
    handshake();
    @(negedge clk);
    chk("stall_no_second_accept", 32'(busy), 32'd0);

    // key write while waiting on the core is ignored
    accept(8'hA5, 8'h11, c_a);
    @(negedge clk);
    key_wr = 1'b1; key_in = 8'hFF;
    @(negedge clk);
    key_wr = 1'b0;
    chk("waitkey_key", 32'(key_out), 32'h5A);
    wait_valid(c_v);
    chk("waitkey_data", 32'(out_data), 32'hEE);
    chk("waitkey_key_end", 32'(key_out), 32'h5A);
    handshake();

    // core never answers bit 3
    drop_bit = 3;
    accept(8'h77, 8'h88, c_a);
    wait_start(4, c_s);
    c_e = -1; hits = 0;
    for (n = 0; n < 100 && c_e < 0; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) hits++;
      if (err_timeout === 1'b1) c_e = cyc;
    end
    chk("timeout_seen", 32'(c_e >= 0), 32'd1);
    chk("timeout_delay", 32'(c_e - c_s), 32'd16);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_in_ready", 32'(in_ready), 32'd1);
    chk("timeout_data_kept", 32'(out_data), 32'hEE);
    chk("timeout_no_valid", 32'(hits), 32'd0);
    @(negedge clk);
    chk("timeout_one_pulse", 32'(err_timeout), 32'd0);
    drop_bit = -1;

    // reset during bit 5
    accept(8'hC3, 8'h3C, c_a);
    wait_start(6, c_s);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_core_start", 32'(core_start), 32'd0);
    chk("midrst_err", 32'(err_timeout), 32'd0);
    chk("midrst_key", 32'(key_out), 32'h00);
    chk("midrst_data", 32'(out_data), 32'h00);
    chk("midrst_bits", 32'({core_a_bit, core_b_bit}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || err_timeout === 1'b1) hits++;
    end
    chk("midrst_quiet", 32'(hits), 32'd0);

    // back-to-back words with the consumer always ready
    write_key(8'h5A);
    out_ready = 1'b1;
    in_a = 8'h3C; in_b = 8'h0F; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_a = 8'h01; in_b = 8'h02;
    wait_valid(c_v);
    chk("b2b_word1", 32'(out_data), 32'h69);
    @(negedge clk);
    chk("b2b_valid_one_cycle", 32'(out_valid), 32'd0);
    chk("b2b_ready_back", 32'(in_ready), 32'd1);
    c_r = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_start", 32'(core_start), 32'd1);
    wait_valid(c_v);
    chk("b2b_word2", 32'(out_data), 32'h59);
    chk("b2b_latency2", 32'(c_v - c_r), 32'd25);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_done_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
